// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and
// the helper that decides whether an op runs on the iterative datapath.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'h0;
   localparam logic [3:0] ALU_XOR  = 4'h1;
   localparam logic [3:0] ALU_SLL  = 4'h2;
   localparam logic [3:0] ALU_ADD  = 4'h3;
   localparam logic [3:0] ALU_SUB  = 4'h4;
   localparam logic [3:0] ALU_MUL  = 4'h5;
   localparam logic [3:0] ALU_OR   = 4'h6;
   localparam logic [3:0] ALU_SRA  = 4'h7;
   localparam logic [3:0] ALU_SRL  = 4'h8;
   localparam logic [3:0] ALU_SLT  = 4'h9;
   localparam logic [3:0] ALU_SLTU = 4'hA;
   localparam logic [3:0] ALU_DIV  = 4'hB;
   localparam logic [3:0] ALU_DIVU = 4'hC;
   localparam logic [3:0] ALU_REM  = 4'hD;
   localparam logic [3:0] ALU_REMU = 4'hE;
   localparam logic [3:0] ALU_RSVD = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_iter(input logic [3:0] op, input logic fast_mul);
      return ((op == ALU_MUL) && !fast_mul) ||
             (op == ALU_DIV) || (op == ALU_DIVU) ||
             (op == ALU_REM) || (op == ALU_REMU);
   endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response handshake bundle between the EX stage and the ALU.
interface alu_mc_if #(parameter int WIDTH = 32);
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] data1_i;
   logic [WIDTH-1:0] data2_i;
   logic [3:0]       ALUCtrl_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] data_o;
   logic             busy_o;

   modport master (
      output valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
      input  ready_o, valid_o, data_o, busy_o
   );

   modport slave (
      input  valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
      output ready_o, valid_o, data_o, busy_o
   );
endinterface

// File: rtl/alu_mc_iter.sv
// Iterative datapath: shift-add multiply and restoring divide, one step per
// cycle for WIDTH cycles; done_o flags the final step with its result.
module alu_mc_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);
   localparam int CW = $clog2(WIDTH) + 1;

   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] acc_reg, sha_reg, shb_reg;
   logic             is_mul_reg, is_rem_reg, neg_reg;
   logic [WIDTH-1:0] acc_next, sha_next, shb_next, raw;
   logic [WIDTH:0]   rem_sh, rem_sub;
   logic             is_signed, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   always_comb begin
      is_signed = (op_i == ALU_DIV) || (op_i == ALU_REM);
      a_neg     = is_signed && a_i[WIDTH-1];
      b_neg     = is_signed && b_i[WIDTH-1];
      a_mag     = a_neg ? -a_i : a_i;
      b_mag     = b_neg ? -b_i : b_i;
   end

   // Divide: acc holds the partial remainder, sha shifts dividend out and
   // quotient bits in; the borrow of the trial subtraction is rem_sub's MSB.
   always_comb begin
      rem_sh  = {acc_reg, sha_reg[WIDTH-1]};
      rem_sub = rem_sh - {1'b0, shb_reg};
      if (is_mul_reg) begin
         acc_next = acc_reg + (shb_reg[0] ? sha_reg : '0);
         sha_next = sha_reg << 1;
         shb_next = shb_reg >> 1;
      end else begin
         acc_next = rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
         sha_next = {sha_reg[WIDTH-2:0], ~rem_sub[WIDTH]};
         shb_next = shb_reg;
      end
   end

   always_comb begin
      raw      = (is_mul_reg || is_rem_reg) ? acc_next : sha_next;
      result_o = neg_reg ? -raw : raw;
      done_o   = (cnt_reg == CW'(1));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_reg    <= '0;
         acc_reg    <= '0;
         sha_reg    <= '0;
         shb_reg    <= '0;
         is_mul_reg <= 1'b0;
         is_rem_reg <= 1'b0;
         neg_reg    <= 1'b0;
      end else if (start_i) begin
         cnt_reg    <= CW'(WIDTH);
         acc_reg    <= '0;
         is_mul_reg <= (op_i == ALU_MUL);
         is_rem_reg <= (op_i == ALU_REM) || (op_i == ALU_REMU);
         neg_reg    <= ((op_i == ALU_REM) || (op_i == ALU_REMU)) ? a_neg : (a_neg ^ b_neg);
         sha_reg    <= (op_i == ALU_MUL) ? a_i : a_mag;
         shb_reg    <= (op_i == ALU_MUL) ? b_i : b_mag;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - CW'(1);
         acc_reg <= acc_next;
         sha_reg <= sha_next;
         shb_reg <= shb_next;
      end
   end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle ops and divide fast paths resolve
// at acceptance, MUL/DIV/REM run on alu_mc_iter behind a valid/ready FSM.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int FAST_MUL = 0
) (
   input logic     clk_i,
   input logic     rst_i,
   alu_mc_if.slave bus
);
   localparam int SW = $clog2(WIDTH);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] data_reg, single_res, iter_res, a, b;
   logic [3:0]       op;
   logic [SW-1:0]    shamt;
   logic             accept, go_iter, iter_done;
   logic             div_op, signed_div, div_zero, div_ovf, fast_div;

   assign a      = bus.data1_i;
   assign b      = bus.data2_i;
   assign op     = bus.ALUCtrl_i;
   assign shamt  = b[SW-1:0];
   assign accept = bus.valid_i && bus.ready_o;

   always_comb begin
      div_op     = (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
      signed_div = (op == ALU_DIV) || (op == ALU_REM);
      div_zero   = (b == '0);
      div_ovf    = signed_div && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
      fast_div   = div_op && (div_zero || div_ovf);
      go_iter    = is_iter(op, FAST_MUL != 0) && !fast_div;
      single_res = '0;
      case (op)
         ALU_AND:  single_res = a & b;
         ALU_XOR:  single_res = a ^ b;
         ALU_SLL:  single_res = a << shamt;
         ALU_ADD:  single_res = a + b;
         ALU_SUB:  single_res = a - b;
         ALU_MUL:  single_res = (FAST_MUL != 0) ? a * b : '0;
         ALU_OR:   single_res = a | b;
         ALU_SRA:  single_res = WIDTH'($signed(a) >>> shamt);
         ALU_SRL:  single_res = a >> shamt;
         ALU_SLT:  single_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU: single_res = {{(WIDTH-1){1'b0}}, a < b};
         // Only reached on the fast path: divide by zero or signed overflow.
         ALU_DIV, ALU_DIVU: single_res = div_zero ? '1 : a;
         ALU_REM, ALU_REMU: single_res = div_zero ? a : '0;
         default:  single_res = '0;
      endcase
   end

   alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (accept && go_iter),
      .op_i     (op),
      .a_i      (a),
      .b_i      (b),
      .done_o   (iter_done),
      .result_o (iter_res)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (bus.valid_i) state_next = go_iter ? ST_BUSY : ST_DONE;
         ST_BUSY: if (iter_done) state_next = ST_DONE;
         ST_DONE: begin
            if (bus.ready_i) begin
               if (bus.valid_i) state_next = go_iter ? ST_BUSY : ST_DONE;
               else             state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.ready_o = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && bus.ready_i);
      bus.valid_o = (state_reg == ST_DONE);
      bus.busy_o  = (state_reg == ST_BUSY);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                   data_reg <= '0;
      else if (accept && !go_iter) data_reg <= single_res;
      else if (iter_done)          data_reg <= iter_res;
   end

   assign bus.data_o = data_reg;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: driver pushes model results, monitor pops
// and compares data and latency whenever a result is handed over.
`timescale 1ns/1ps
module tb_alu_mc;
   import alu_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk = ~clk;

   alu_mc_if #(.WIDTH(W)) bus ();
   alu_mc_if #(.WIDTH(W)) fbus ();

   alu_mc #(.WIDTH(W), .FAST_MUL(0)) dut      (.clk_i(clk), .rst_i(rst_i), .bus(bus));
   alu_mc #(.WIDTH(W), .FAST_MUL(1)) dut_fast (.clk_i(clk), .rst_i(rst_i), .bus(fbus));

   typedef struct {
      logic [31:0] exp;
      int          acc;
      int          lat;
      logic [3:0]  op;
   } item_t;

   item_t sb[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled
   int    pop_edge = 0;
   bit    fast_done = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa, sbv;
      logic ovf;
      sa  = a;
      sbv = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         4'h0: return a & b;
         4'h1: return a ^ b;
         4'h2: return a << b[4:0];
         4'h3: return a + b;
         4'h4: return a - b;
         4'h5: return a * b;
         4'h6: return a | b;
         4'h7: return 32'(sa >>> b[4:0]);
         4'h8: return a >> b[4:0];
         4'h9: return (sa < sbv) ? 32'd1 : 32'd0;
         4'hA: return (a < b) ? 32'd1 : 32'd0;
         4'hB: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sbv));
         4'hC: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'hD: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sbv));
         4'hE: return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   // Cycles from the accepting edge to the first cycle valid_o is seen.
   function automatic int lat_of(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic ovf;
      ovf = ((op == 4'hB) || (op == 4'hD)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (op == 4'h5) return W;
      if ((op >= 4'hB) && (op <= 4'hE) && (b != 0) && !ovf) return W;
      return 0;
   endfunction

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int acc);
      int waited;
      waited = 0;
      @(negedge clk);
      bus.valid_i   = 1'b1;
      bus.ALUCtrl_i = op;
      bus.data1_i   = a;
      bus.data2_i   = b;
      #2;
      while (!bus.ready_o && waited < 300) begin
         @(negedge clk);
         #2;
         waited++;
      end
      if (!bus.ready_o) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout op=%0h ready_o=0 want 1", op);
         bus.valid_i = 1'b0;
         acc = -1;
         return;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      sb.push_back('{exp: model(op, a, b), acc: cyc, lat: lat_of(op, a, b), op: op});
      bus.valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout pending=%0d want 0", sb.size());
         sb.delete();
      end
   endtask

   // Monitor: owns ready_i, checks every handed-over result.
   initial begin : monitor
      item_t       it;
      bit          head_seen;
      bit          stalled;
      logic [31:0] prev_data;
      head_seen = 0;
      stalled   = 0;
      prev_data = '0;
      bus.ready_i = 1'b1;
      forever begin
         @(negedge clk);
         if (rdy_mode == 0) bus.ready_i = ($urandom_range(0, 3) != 0);
         else               bus.ready_i = (rdy_mode == 1);
         #1;
         if (rst_i) begin
            head_seen = 0;
            stalled   = 0;
         end else if (bus.valid_o) begin
            if (sb.size() == 0) begin
               chk("spurious_valid", 32'(bus.valid_o), 32'd0);
            end else begin
               it = sb[0];
               if (!head_seen) begin
                  chk("latency", 32'(cyc - it.acc), 32'(it.lat));
                  head_seen = 1;
               end
               if (stalled) chk("stall_hold", bus.data_o, prev_data);
               if (bus.ready_i) begin
                  chk("data", bus.data_o, it.exp);
                  chk("ready_o_done", 32'(bus.ready_o), 32'd1);
                  $display("txn op=%0h data=%h exp=%h acc=%0d out=%0d", it.op, bus.data_o, it.exp, it.acc, cyc);
                  void'(sb.pop_front());
                  pop_edge  = cyc + 1;
                  head_seen = 0;
                  stalled   = 0;
               end else begin
                  chk("ready_o_stall", 32'(bus.ready_o), 32'd0);
                  stalled   = 1;
                  prev_data = bus.data_o;
               end
            end
         end
      end
   end

   // FAST_MUL=1 instance: MUL completes one cycle after acceptance.
   initial begin : fast_path
      logic [31:0] fa, fb;
      fbus.valid_i   = 1'b0;
      fbus.ready_i   = 1'b1;
      fbus.ALUCtrl_i = ALU_MUL;
      fbus.data1_i   = '0;
      fbus.data2_i   = '0;
      wait (!rst_i);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         fa = (i == 0) ? 32'h0001_0000 : $urandom;
         fb = (i == 0) ? 32'h0001_0003 : $urandom;
         @(negedge clk);
         fbus.valid_i = 1'b1;
         fbus.data1_i = fa;
         fbus.data2_i = fb;
         #2 chk("fast_ready", 32'(fbus.ready_o), 32'd1);
         @(negedge clk);
         fbus.valid_i = 1'b0;
         #2;
         chk("fast_valid", 32'(fbus.valid_o), 32'd1);
         chk("fast_data", fbus.data_o, fa * fb);
         $display("txn fast_mul a=%h b=%h data=%h", fa, fb, fbus.data_o);
      end
      fast_done = 1;
   end

   initial begin : driver
      int acc, acc2, n;
      int accs[4];
      logic [31:0] ra, rb;
      logic [3:0]  rop;
      bus.valid_i   = 1'b0;
      bus.ALUCtrl_i = '0;
      bus.data1_i   = '0;
      bus.data2_i   = '0;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      #2;
      chk("reset_ready_o", 32'(bus.ready_o), 32'd1);
      chk("reset_valid_o", 32'(bus.valid_o), 32'd0);
      chk("reset_busy_o",  32'(bus.busy_o),  32'd0);
      chk("reset_data_o",  bus.data_o,       32'd0);

      issue(ALU_ADD, 32'd7, 32'hFFFF_FFFD, acc);
      for (int i = 0; i < 4; i++) issue(ALU_ADD, $urandom, $urandom, accs[i]);
      for (int i = 1; i < 4; i++) chk("back_to_back", 32'(accs[i] - accs[i-1]), 32'd1);

      issue(ALU_MUL, 32'h0001_0000, 32'h0001_0003, acc);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #2;
         if (!bus.busy_o) break;
         if (n == 3) chk("ready_o_busy", 32'(bus.ready_o), 32'd0);
         n++;
      end
      chk("busy_cycles", 32'(n), 32'(W));

      issue(ALU_DIV,  32'hFFFF_FFF9, 32'd2, acc);
      issue(ALU_REM,  32'hFFFF_FFF9, 32'd2, acc);
      issue(ALU_DIVU, 32'd100, 32'd7, acc);
      issue(ALU_REMU, 32'd100, 32'd7, acc);
      issue(ALU_DIVU, 32'd5, 32'd0, acc);
      issue(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, acc);
      issue(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, acc);
      drain();

      // Stall the consumer, then release: the waiting op must be taken
      // on the same edge that releases the held result.
      rdy_mode = 2;
      issue(ALU_XOR, 32'hA5A5_0F0F, 32'h0FF0_1234, acc);
      fork
         issue(ALU_SUB, 32'd10, 32'd20, acc2);
         begin
            repeat (11) @(negedge clk);
            rdy_mode = 1;
         end
      join
      chk("release_same_cycle", 32'(acc2), 32'(pop_edge));
      drain();

      wait (fast_done);
      issue(ALU_DIV, 32'hFFFF_FF00, 32'd3, acc);
      repeat (4) @(posedge clk);
      #3;
      chk("busy_mid_div", 32'(bus.busy_o), 32'd1);
      rst_i = 1'b1;
      #1;
      chk("async_rst_ready_o", 32'(bus.ready_o), 32'd1);
      chk("async_rst_valid_o", 32'(bus.valid_o), 32'd0);
      chk("async_rst_busy_o",  32'(bus.busy_o),  32'd0);
      chk("async_rst_data_o",  bus.data_o,       32'd0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      issue(ALU_ADD, 32'd1234, 32'd4321, acc);
      drain();

      rdy_mode = 0;
      for (int i = 0; i < 60; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 9))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'($urandom_range(1, 40));
            default: rb = $urandom;
         endcase
         issue(rop, ra, rb, acc);
      end
      drain();
      rdy_mode = 1;
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog time_limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end
endmodule
